// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register family: occupancy encoding,
// the matching FSM state type, and the default MEM->WB payload widths.
package pipe_pkg;

  // Default payload widths at the MEM->WB boundary
  localparam int WB_DATA_W  = 64;
  localparam int WB_CTRL_W  = 2;
  localparam int REG_ADDR_W = 5;

  // Occupancy encoding; the FSM state is the occupancy itself
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = CNT_EMPTY,
    ST_ONE   = CNT_ONE,
    ST_TWO   = CNT_TWO
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (data, ctrl, rd) with a load enable and separate
// clear enables for the control bits and for the data/rd payload.
// Clears take priority over load.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              clear_payload,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [ADDR_W-1:0] d_rd,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [ADDR_W-1:0] q_rd
);

  // Control bits: cleared on reset/flush, otherwise loaded on demand
  always_ff @(posedge clk) begin
    if (clear_ctrl) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
    end
  end

  // Data and destination index: cleared only when asked, otherwise loaded
  always_ff @(posedge clk) begin
    if (clear_payload) begin
      q_data <= '0;
      q_rd   <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_rd   <= d_rd;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a valid/ready handshake and a two-entry
// skid buffer. Outputs always come from the main slot; the skid slot only
// catches the beat accepted in the cycle the consumer stalls.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// edge (accept = in_valid_i & in_ready_o, pop = out_valid_o & out_ready_i).
// The producer may not assume anything about ready before that edge, and
// in_ready_o is a flop, so there is no combinational path from out_ready_i.
//
// count_o is the FSM state (occupancy) and doubles as the debug view.
module wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W              = WB_DATA_W,
  parameter int CTRL_W              = WB_CTRL_W,
  parameter int ADDR_W              = REG_ADDR_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [ADDR_W-1:0] out_rd_o,
  output logic [1:0]        count_o
);

  occ_e state_q, state_d;
  logic ready_q;
  logic accept, pop;
  logic main_load, main_from_skid, skid_load;
  logic clear_ctrl, clear_payload;

  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [ADDR_W-1:0] main_rd, skid_rd, main_d_rd;

  assign accept      = in_valid_i & ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign pop         = out_valid_o & out_ready_i;

  // Reset wipes everything; flush always drops ctrl and optionally payload
  assign clear_ctrl    = rst_i | flush_i;
  assign clear_payload = rst_i | (flush_i & CLEAR_DATA_ON_FLUSH);

  // Next-state and slot-load decode; flush overrides every transition
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // State register and registered ready (ready whenever not full next cycle)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  // Main slot refills from the skid entry first, keeping FIFO order
  always_comb begin
    main_d_data = in_data_i;
    main_d_ctrl = in_ctrl_i;
    main_d_rd   = in_rd_i;
    if (main_from_skid) begin
      main_d_data = skid_data;
      main_d_ctrl = skid_ctrl;
      main_d_rd   = skid_rd;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W)
  ) u_main (
    .clk           (clk_i),
    .load          (main_load),
    .clear_ctrl    (clear_ctrl),
    .clear_payload (clear_payload),
    .d_data        (main_d_data),
    .d_ctrl        (main_d_ctrl),
    .d_rd          (main_d_rd),
    .q_data        (main_data),
    .q_ctrl        (main_ctrl),
    .q_rd          (main_rd)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk           (clk_i),
    .load          (skid_load),
    .clear_ctrl    (clear_ctrl),
    .clear_payload (clear_payload),
    .d_data        (in_data_i),
    .d_ctrl        (in_ctrl_i),
    .d_rd          (in_rd_i),
    .q_data        (skid_data),
    .q_ctrl        (skid_ctrl),
    .q_rd          (skid_rd)
  );

  assign in_ready_o = ready_q;
  assign out_data_o = main_data;
  assign out_rd_o   = main_rd;
  // Bubbles never carry live control bits downstream
  assign out_ctrl_o = main_ctrl & {CTRL_W{out_valid_o}};
  assign count_o    = state_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: two instances (flush keeps data / flush clears data)
// share stimulus. The reference model is a queue of beats the block should
// be holding: accepted beats are pushed, popped beats leave the front,
// flush/reset empty it.
module tb_wb_pipe_reg;

  localparam int DW = 64;
  localparam int CW = 2;
  localparam int AW = 5;
  localparam int W  = DW + CW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [AW-1:0] in_rd = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [AW-1:0] out_rd0, out_rd1;
  logic [1:0]    count0, count1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_beat = '0;
  logic         cleared1 = 1'b1;
  logic         started = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;

  wb_pipe_reg #(.CLEAR_DATA_ON_FLUSH(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_rd_i(in_rd), .flush_i(flush),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_data_o(out_data0),
    .out_ctrl_o(out_ctrl0), .out_rd_o(out_rd0), .count_o(count0)
  );

  wb_pipe_reg #(.CLEAR_DATA_ON_FLUSH(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .in_rd_i(in_rd), .flush_i(flush),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_data_o(out_data1),
    .out_ctrl_o(out_ctrl1), .out_rd_o(out_rd1), .count_o(count1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one cycle of inputs, then record the beat if accepted
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic [AW-1:0] r, input logic ordy, input logic fl,
                      input logic rs, output logic got);
    logic [W-1:0] beat;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_rd     = r;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(negedge clk);
    got  = in_valid & in_ready0 & ~flush & ~rst;
    beat = {in_data, in_ctrl, in_rd};
    @(posedge clk);
    #1;
    if (got) begin
      exp_q.push_back(beat);
      cleared1 = 1'b0;
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    logic g;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0, g);
  endtask

  // Scoreboard update at each edge: pops, flushes and resets
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_beat = '0;
      cleared1  = 1'b1;
      started   = 1'b1;
    end else begin
      if (exp_q.size() > 0) last_beat = exp_q[0];
      if (out_valid0 && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (flush) begin
        exp_q.delete();
        cleared1 = 1'b1;
      end
    end
  end

  // Monitor: compare both instances against the model mid-cycle
  always @(negedge clk) begin
    int sz;
    if (started) begin
      sz = exp_q.size();
      chk("count0", count0, sz);
      chk("count1", count1, sz);
      chk("ready0", in_ready0, (sz != 2));
      chk("ready1", in_ready1, (sz != 2));
      chk("valid0", out_valid0, (sz != 0));
      chk("valid1", out_valid1, (sz != 0));
      if (sz > 0) begin
        chk("beat0", {out_data0, out_ctrl0, out_rd0}, exp_q[0]);
        chk("beat1", {out_data1, out_ctrl1, out_rd1}, exp_q[0]);
      end else begin
        chk("bubble_ctrl0", out_ctrl0, 0);
        chk("bubble_ctrl1", out_ctrl1, 0);
        chk("hold0", {out_data0, out_rd0}, {last_beat[W-1:CW+AW], last_beat[AW-1:0]});
        if (cleared1) chk("clear1", {out_data1, out_rd1}, 0);
      end
    end
  end

  initial begin
    logic g;
    // Reset with a beat presented: must not be accepted
    step(1'b1, 64'hdead, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, g);
    step(1'b1, 64'hdead, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, g);
    idle(1'b1, 2);
    // Streaming at full rate
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 2'b11, AW'(i), 1'b1, 1'b0, 1'b0, g);
    idle(1'b1, 2);
    // Backpressure: A, B fill the block, C waits until space opens
    step(1'b1, 64'hA, 2'b10, 5'd10, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'hB, 2'b01, 5'd11, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'hC, 2'b11, 5'd12, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'hC, 2'b11, 5'd12, 1'b0, 1'b0, 1'b0, g);
    g = 1'b0;
    for (int k = 0; k < 8 && !g; k++) step(1'b1, 64'hC, 2'b11, 5'd12, 1'b1, 1'b0, 1'b0, g);
    idle(1'b1, 4);
    // Bubble gating after a pop
    step(1'b1, 64'h1234_5678, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0, g);
    idle(1'b1, 3);
    // Flush at count 2 with a concurrent beat, no pop
    step(1'b1, 64'h11, 2'b11, 5'd1, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h22, 2'b11, 5'd2, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h33, 2'b11, 5'd3, 1'b0, 1'b1, 1'b0, g);
    idle(1'b0, 2);
    // Flush at count 2 with a concurrent pop
    step(1'b1, 64'h44, 2'b10, 5'd4, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h55, 2'b01, 5'd5, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h66, 2'b11, 5'd6, 1'b1, 1'b1, 1'b0, g);
    idle(1'b1, 2);
    // Reset and flush together, mid-operation at count 2
    step(1'b1, 64'h77, 2'b11, 5'd7, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h88, 2'b11, 5'd8, 1'b0, 1'b0, 1'b0, g);
    step(1'b1, 64'h99, 2'b11, 5'd9, 1'b1, 1'b1, 1'b1, g);
    idle(1'b1, 2);
    // Random valid/ready with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, CW'($urandom_range(0, 3)),
           AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 511) == 0), g);
    end
    idle(1'b1, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
